// File: rtl/vga_timing_gen_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
// All coordinates are 10 bits, so a frame may be at most 1024x1024.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int COORD_MAX = 1024;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    function automatic coord_t to_coord(input int val);
        return coord_t'(val);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Async-reset shift register that realigns blank/sync with the pixel data pipeline.
// DEPTH=0 degenerates to a plain wire.
module sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
            end else begin
                stage_q[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters, registered blank/sync/frame tick,
// a frame counter, and pipeline-aligned copies of blank/hs/vs for the DAC.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIPE_DLY = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       blank_d,
    output logic       hs_d,
    output logic       vs_d,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
    end

    localparam coord_t H_LAST   = to_coord(H_TOTAL - 1);
    localparam coord_t V_LAST   = to_coord(V_TOTAL - 1);
    localparam coord_t H_VIS    = to_coord(H_ACTIVE);
    localparam coord_t V_VIS    = to_coord(V_ACTIVE);
    localparam coord_t HS_START = to_coord(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = to_coord(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = to_coord(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = to_coord(V_ACTIVE + V_FP + V_SYNC);

    coord_t     x_q, y_q, x_nxt, y_nxt;
    logic       blank_q, hs_q, vs_q, tick_q;
    logic [7:0] fcnt_q;

    always_comb begin
        x_nxt = x_q + 10'd1;
        y_nxt = y_q;
        if (x_q == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        end
    end

    // Flags are decoded from the next-state counters so they land in the same
    // cycle as the coordinates they describe, straight out of flops.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            blank_q <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            tick_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            blank_q <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            hs_q    <= (x_nxt >= HS_START && x_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
            vs_q    <= (y_nxt >= VS_START && y_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
            tick_q  <= (x_nxt == H_LAST) && (y_nxt == V_LAST);
            if (tick_q) fcnt_q <= fcnt_q + 8'd1;
        end
    end

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL ({1'b0, ~SYNC_POL, ~SYNC_POL})
    ) u_sync_dly (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .d     ({blank_q, hs_q, vs_q}),
        .q     ({blank_d, hs_d, vs_d})
    );

    assign DrawX      = x_q;
    assign DrawY      = y_q;
    assign blank      = blank_q;
    assign hs         = hs_q;
    assign vs         = vs_q;
    assign frame_tick = tick_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size, scaled and tiny timing instances checked
// against an arithmetic raster model, plus fixed vectors and random resets.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, dly;
        bit pol;
    } timing_t;

    typedef struct {
        int x, y;
        bit bl, h, v, tk;
        int fc;
    } snap_t;

    typedef struct {
        int         t;
        logic [9:0] x, y;
        logic       bl, hs, vs, bd;
    } vec_t;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    int   t = -1;
    int   checks = 0;
    int   errors = 0;

    timing_t ta, tb, tc;

    logic [9:0] ax, ay, bx, by, cx, cy;
    logic       ab, ahs, avs, abd, ahsd, avsd, atk;
    logic       bb, bhs, bvs, bbd, bhsd, bvsd, btk;
    logic       cb, chs, cvs, cbd, chsd, cvsd, ctk;
    logic [7:0] afc, bfc, cfc;

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen u_a (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(ax), .DrawY(ay),
        .blank(ab), .hs(ahs), .vs(avs), .blank_d(abd), .hs_d(ahsd), .vs_d(avsd),
        .frame_tick(atk), .frame_cnt(afc));

    vga_timing_gen #(
        .H_ACTIVE(24), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .PIPE_DLY(3), .SYNC_POL(1'b1)
    ) u_b (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(bx), .DrawY(by),
        .blank(bb), .hs(bhs), .vs(bvs), .blank_d(bbd), .hs_d(bhsd), .vs_d(bvsd),
        .frame_tick(btk), .frame_cnt(bfc));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIPE_DLY(0), .SYNC_POL(1'b0)
    ) u_c (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(cx), .DrawY(cy),
        .blank(cb), .hs(chs), .vs(cvs), .blank_d(cbd), .hs_d(chsd), .vs_d(cvsd),
        .frame_tick(ctk), .frame_cnt(cfc));

    // Raster state after t cycles since reset release; t<0 means held in reset.
    function automatic snap_t snap(input int tt, input timing_t tm);
        snap_t s;
        int ht, vt, fr, p;
        ht = tm.ha + tm.hf + tm.hs + tm.hb;
        vt = tm.va + tm.vf + tm.vs + tm.vb;
        fr = ht * vt;
        if (tt < 0) begin
            s.x = ht - 1; s.y = vt - 1; s.bl = 0;
            s.h = !tm.pol; s.v = !tm.pol; s.tk = 0; s.fc = 0;
        end else begin
            p    = tt % fr;
            s.x  = p % ht;
            s.y  = p / ht;
            s.bl = (s.x < tm.ha) && (s.y < tm.va);
            s.h  = (s.x >= tm.ha + tm.hf && s.x < tm.ha + tm.hf + tm.hs) ? tm.pol : !tm.pol;
            s.v  = (s.y >= tm.va + tm.vf && s.y < tm.va + tm.vf + tm.vs) ? tm.pol : !tm.pol;
            s.tk = (p == fr - 1);
            s.fc = (tt / fr) % 256;
        end
        return s;
    endfunction

    function automatic logic [34:0] expv(input int tt, input timing_t tm);
        snap_t s, d;
        s = snap(tt, tm);
        d = snap(tt - tm.dly, tm);
        return {10'(s.x), 10'(s.y), s.bl, s.h, s.v, d.bl, d.h, d.v, s.tk, 8'(s.fc)};
    endfunction

    task automatic cmp(input string nm, input logic [34:0] act, input logic [34:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 25)
                $display("FAIL %s t=%0d actual=%h required=%h", nm, t, act, req);
        end
    endtask

    task automatic check_models();
        cmp("model_a", {ax, ay, ab, ahs, avs, abd, ahsd, avsd, atk, afc}, expv(t, ta));
        cmp("model_b", {bx, by, bb, bhs, bvs, bbd, bhsd, bvsd, btk, bfc}, expv(t, tb));
        cmp("model_c", {cx, cy, cb, chs, cvs, cbd, chsd, cvsd, ctk, cfc}, expv(t, tc));
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
        if (reset_n) t++;
        check_models();
    endtask

    // Async assertion away from the clock edge, then check the reset values at once.
    task automatic do_reset(input int hold);
        @(posedge vga_clk);
        #1;
        reset_n = 1'b0;
        t = -1;
        #1;
        check_models();
        repeat (hold) step();
        reset_n = 1'b1;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (t < target && guard < 20000) begin
            step();
            guard++;
        end
        if (t < target) begin
            cmp("run_timeout", 35'(t), 35'(target));
        end
    endtask

    vec_t tbl[$];
    int   hs_cnt, hs_first, vs_cnt, vs_first;

    initial begin
        ta = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, dly:2, pol:1'b0};
        tb = '{ha:24,  hf:4,  hs:8,  hb:4,  va:12,  vf:2,  vs:2, vb:4,  dly:3, pol:1'b1};
        tc = '{ha:4,   hf:1,  hs:2,  hb:1,  va:1,   vf:1,  vs:1, vb:1,  dly:0, pol:1'b0};

        tbl = '{
            '{t:0,    x:0,   y:0, bl:1, hs:1, vs:1, bd:0},
            '{t:1,    x:1,   y:0, bl:1, hs:1, vs:1, bd:0},
            '{t:2,    x:2,   y:0, bl:1, hs:1, vs:1, bd:1},
            '{t:639,  x:639, y:0, bl:1, hs:1, vs:1, bd:1},
            '{t:640,  x:640, y:0, bl:0, hs:1, vs:1, bd:1},
            '{t:641,  x:641, y:0, bl:0, hs:1, vs:1, bd:1},
            '{t:642,  x:642, y:0, bl:0, hs:1, vs:1, bd:0},
            '{t:655,  x:655, y:0, bl:0, hs:1, vs:1, bd:0},
            '{t:656,  x:656, y:0, bl:0, hs:0, vs:1, bd:0},
            '{t:751,  x:751, y:0, bl:0, hs:0, vs:1, bd:0},
            '{t:752,  x:752, y:0, bl:0, hs:1, vs:1, bd:0},
            '{t:799,  x:799, y:0, bl:0, hs:1, vs:1, bd:0},
            '{t:800,  x:0,   y:1, bl:1, hs:1, vs:1, bd:0},
            '{t:1599, x:799, y:1, bl:0, hs:1, vs:1, bd:0}
        };

        // Reset held for 10 cycles shows the parked end-of-frame position.
        repeat (10) step();
        cmp("reset_state_a", {25'd0, ax, ay, ab, ahs, avs, atk, afc} >> 0,
            {25'd0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
        reset_n = 1'b1;

        // Fixed vectors on the full-size 640x480 instance.
        foreach (tbl[i]) begin
            run_to(tbl[i].t);
            cmp("vector_a", {ax, ay, ab, ahs, avs, abd},
                {tbl[i].x, tbl[i].y, tbl[i].bl, tbl[i].hs, tbl[i].vs, tbl[i].bd});
        end

        // Sync pulse widths from a fresh reset: hs on the full-size line, vs on the scaled frame.
        do_reset(3);
        hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1;
        for (int i = 0; i < 800; i++) begin
            step();
            if (ahs == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = t;
            end
            if (bvs == 1'b1) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = t;
            end
        end
        cmp("hs_width_a", 35'(hs_cnt), 35'd96);
        cmp("hs_start_a", 35'(hs_first), 35'd656);
        cmp("vs_width_b", 35'(vs_cnt), 35'd80);
        cmp("vs_start_b", 35'(vs_first), 35'd560);

        // Frame counter wrap on the 8x4 instance (32 cycles per frame).
        run_to(8191);
        cmp("wrap_c_255", {ctk, cfc}, {1'b1, 8'd255});
        run_to(8192);
        cmp("wrap_c_0", {cx, cy, ctk, cfc}, {10'd0, 10'd0, 1'b0, 8'd0});
        run_to(8224);
        cmp("wrap_c_1", {ctk, cfc}, {1'b0, 8'd1});
        cmp("frames_b", 35'(bfc), 35'd10);

        // Random mid-frame resets of random length.
        for (int k = 0; k < 4; k++) begin
            run_to(t + int'($urandom_range(50, 3000)));
            do_reset(int'($urandom_range(1, 5)));
            step();
            cmp("restart_a", {ax, ay, ab}, {10'd0, 10'd0, 1'b1});
        end
        run_to(t + 900);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
